ssub_result_stage: RTL and testbench

- Registered output stage directly downstream of the signed subtractor.
- Captures operands A, B and the subtractor's 32-bit difference.
- Derives status flags (zero, negative, signed overflow, borrow) and presents result plus flags to the writeback/flag-register consumer over a valid/ready handshake.
- Two-entry skid buffer keeps full throughput under consumer back-pressure; a saturating counter tallies signed-overflow events.

---
 rtl/ssub_result_stage.sv | 157 +++++++++++++++
 tb/tb_ssub_result_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ssub_result_stage.sv
// Registered result stage for the signed subtractor. It captures A, B and
// diff, derives the Z/N/V/C flags when a triple is accepted, and offers the
// result and flags to the consumer over valid/ready. A two-entry skid buffer
// keeps full throughput under back-pressure, and a saturating counter tallies
// signed-overflow events at acceptance.
module ssub_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] diff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_c,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    localparam int MSB = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } state_t;

    // One buffered entry: the difference plus the flags derived from it.
    typedef struct packed {
        logic             z;
        logic             n;
        logic             v;
        logic             c;
        logic [WIDTH-1:0] res;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, new_entry;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic accept, deliver;
    logic load_main_new, load_main_skid, load_skid;

    // Handshakes depend only on the state register, so in_ready has no
    // combinational path from out_ready.
    assign accept  = in_valid  & (state_q != ST_FULL2);
    assign deliver = out_ready & (state_q != ST_EMPTY);

    // Flags are derived from the incoming triple and stored with the result.
    assign new_entry.v   = (A[MSB] != B[MSB]) & (diff[MSB] != A[MSB]);
    assign new_entry.c   = (A < B);
    assign new_entry.z   = (diff == '0);
    assign new_entry.n   = diff[MSB];
    assign new_entry.res = diff;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, buffer steering and handshake outputs.
    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        out_valid      = 1'b0;
        in_ready       = 1'b1;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_new = 1'b1;
                    state_d       = ST_FULL1;
                end
            end
            ST_FULL1: begin
                out_valid = 1'b1;
                if (accept && deliver) begin
                    load_main_new = 1'b1;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL2;
                end
            end
            ST_FULL2: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                if (deliver) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_FULL1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Main (output) and skid entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_new) begin
                main_q <= new_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    // Overflow counter next value: clear wins, otherwise saturating increment.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = '0;
        end else if (accept && new_entry.v && (ovf_q != CNT_MAX)) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign result    = main_q.res;
    assign flag_z    = main_q.z;
    assign flag_n    = main_q.n;
    assign flag_v    = main_q.v;
    assign flag_c    = main_q.c;
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_ssub_result_stage.sv
// Directed bench for ssub_result_stage: flags, back-pressure ordering,
// overflow counter saturation/clear and mid-operation reset.
module tb_ssub_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A, B, diff;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z, flag_n, flag_v, flag_c;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr;
    logic [3:0]       flags;

    int n_checks = 0;
    int n_fail   = 0;

    assign flags = {flag_z, flag_n, flag_v, flag_c};

    always #5 clk = ~clk;

    ssub_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .diff      (diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_c    (flag_c),
        .ovf_count (ovf_count),
        .ovf_clr   (ovf_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        diff     = d;
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({pfx, "_in_ready"},  32'(in_ready),  32'd1);
        check_eq({pfx, "_result"},    result,         32'd0);
        check_eq({pfx, "_flags"},     32'(flags),     32'd0);
        check_eq({pfx, "_ovf"},       32'(ovf_count), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        A         = '0;
        B         = '0;
        diff      = '0;
        step();
        step();
        reset = 1'b0;
        check_reset_state("rst");

        // Single transfer, consumer always ready. Flags are {z,n,v,c}.
        out_ready = 1'b1;
        put(32'd5, 32'd7, 32'hFFFF_FFFE);
        step();
        check_eq("single_valid",  32'(out_valid), 32'd1);
        check_eq("single_result", result,         32'hFFFF_FFFE);
        check_eq("single_flags",  32'(flags),     32'b0101);

        // Overflow: negative minus positive.
        put(32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        step();
        check_eq("ovf1_result", result,         32'h7FFF_FFFF);
        check_eq("ovf1_flags",  32'(flags),     32'b0010);
        check_eq("ovf1_count",  32'(ovf_count), 32'd1);

        // Overflow: positive minus negative.
        put(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000);
        step();
        check_eq("ovf2_result", result,         32'h8000_0000);
        check_eq("ovf2_flags",  32'(flags),     32'b0111);
        check_eq("ovf2_count",  32'(ovf_count), 32'd2);

        // Equal operands.
        put(32'h1234_5678, 32'h1234_5678, 32'd0);
        step();
        check_eq("zero_result", result,     32'd0);
        check_eq("zero_flags",  32'(flags), 32'b1000);
        in_valid = 1'b0;
        step();
        check_eq("drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure: third triple must wait until space frees up.
        out_ready = 1'b0;
        put(32'd1, 32'd0, 32'd1);
        step();
        check_eq("bp1_in_ready", 32'(in_ready), 32'd1);
        check_eq("bp1_result",   result,        32'd1);
        put(32'd2, 32'd0, 32'd2);
        step();
        check_eq("bp2_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp2_result",   result,        32'd1);
        put(32'd3, 32'd0, 32'd3);
        step();
        check_eq("bp3_in_ready", 32'(in_ready),  32'd0);
        check_eq("bp3_hold",     result,         32'd1);
        check_eq("bp3_valid",    32'(out_valid), 32'd1);
        step();
        check_eq("bp4_hold",     result,         32'd1);
        out_ready = 1'b1;
        step();
        check_eq("rel1_result",   result,        32'd2);
        check_eq("rel1_in_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("rel2_result",   result,        32'd3);
        in_valid = 1'b0;
        step();
        check_eq("rel3_valid",    32'(out_valid), 32'd0);

        // Saturation with a 2-bit counter, then clear beats a same-cycle increment.
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_eq("clr_count", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            put(32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
            step();
            check_eq($sformatf("sat%0d_count", i), 32'(ovf_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr  = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_pri_count", 32'(ovf_count), 32'd0);
        step();

        // Reset while holding two entries.
        out_ready = 1'b0;
        put(32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        step();
        put(32'd9, 32'd4, 32'd5);
        step();
        check_eq("f2_in_ready", 32'(in_ready),  32'd0);
        check_eq("f2_count",    32'(ovf_count), 32'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("mid_rst");

        out_ready = 1'b1;
        put(32'd5, 32'd7, 32'hFFFF_FFFE);
        step();
        in_valid = 1'b0;
        check_eq("post_valid",  32'(out_valid), 32'd1);
        check_eq("post_result", result,         32'hFFFF_FFFE);
        check_eq("post_flags",  32'(flags),     32'b0101);
        step();
        check_eq("post_drain",  32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
